// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: ResultSrc encoding and architectural width constants.
package wb_regfile_pkg;

    localparam int RV_XLEN   = 32;
    localparam int RV_NREG   = 32;
    localparam int RV_REG_AW = $clog2(RV_NREG);

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Two-read / one-write integer register file with hard-wired x0.
// Optional write-first bypass when WB_RF_BYPASS_EN is defined; read-old otherwise.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = RV_XLEN,
    parameter int NREG = RV_NREG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2
);

    // Cell 0 is cleared on reset and never written, reads of index 0 are forced to zero anyway.
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef WB_RF_BYPASS_EN
    // A write that reset will discard must not be forwarded either.
    logic fwd;
    assign fwd = we & ~rst;
`endif

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
`ifdef WB_RF_BYPASS_EN
        if (fwd && (waddr == raddr1)) rdata1 = wdata;
        if (fwd && (waddr == raddr2)) rdata2 = wdata;
`endif
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result mux, register-file write enable and retired-instruction counter.
// Build option WB_RF_BYPASS_EN selects write-first reads in the register file.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = RV_XLEN,
    parameter int NREG = RV_NREG,
    parameter int CNTW = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ValidW,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcW,
    input  logic [XLEN-1:0]          ALUResultW,
    input  logic [XLEN-1:0]          ReadDataW,
    input  logic [XLEN-1:0]          PCPlus4W,
    input  logic [XLEN-1:0]          ImmExtW,
    input  logic [$clog2(NREG)-1:0]  RdW,
    input  logic [$clog2(NREG)-1:0]  Rs1D,
    input  logic [$clog2(NREG)-1:0]  Rs2D,
    output logic [XLEN-1:0]          RD1D,
    output logic [XLEN-1:0]          RD2D,
    output logic [XLEN-1:0]          ResultW,
    output logic [CNTW-1:0]          InstRetW
);

    logic            we;
    logic [CNTW-1:0] instret_q;

    always_comb begin
        ResultW = ALUResultW;
        case (result_src_e'(ResultSrcW))
            RES_ALU: ResultW = ALUResultW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            RES_IMM: ResultW = ImmExtW;
            default: ResultW = ALUResultW;
        endcase
    end

    assign we = ValidW & RegWriteW & (RdW != '0);

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (RdW),
        .wdata  (ResultW),
        .raddr1 (Rs1D),
        .raddr2 (Rs2D),
        .rdata1 (RD1D),
        .rdata2 (RD2D)
    );

    // Stores and branches retire too, so only ValidW matters; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (ValidW) begin
            instret_q <= instret_q + CNTW'(1);
        end
    end

    assign InstRetW = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks plus randomized traffic against a behavioural model.
// Honors WB_RF_BYPASS_EN to choose write-first or read-old expectations.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        ValidW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW;
    logic [4:0]  RdW, Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstRetW;
    logic [31:0] s_RD1D, s_RD2D, s_ResultW;
    logic [3:0]  s_InstRetW;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // Model state: plain array of architectural registers and an unbounded retire count.
    logic [31:0] mregs [32];
    longint unsigned mcnt;

    wb_regfile dut (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW),
        .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
        .InstRetW(InstRetW)
    );

    wb_regfile #(.CNTW(4)) dut_small (
        .clk(clk), .rst(rst), .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW),
        .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(s_RD1D), .RD2D(s_RD2D), .ResultW(s_ResultW),
        .InstRetW(s_InstRetW)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_result();
        logic [31:0] cand [4];
        cand[0] = ALUResultW;
        cand[1] = ReadDataW;
        cand[2] = PCPlus4W;
        cand[3] = ImmExtW;
        return cand[ResultSrcW];
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef WB_RF_BYPASS_EN
        if (!rst && ValidW && RegWriteW && RdW != 0 && RdW == idx) return exp_result();
`endif
        return mregs[idx];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            mcnt = 0;
        end else begin
            if (ValidW && RegWriteW && RdW != 0) mregs[RdW] = exp_result();
            if (ValidW) mcnt = mcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("result", {32'h0, ResultW}, {32'h0, exp_result()});
            check("instret", InstRetW, mcnt);
            check("instret_w4", {60'h0, s_InstRetW}, {60'h0, mcnt[3:0]});
            if (!rst) begin
                check("rd1", {32'h0, RD1D}, {32'h0, exp_read(Rs1D)});
                check("rd2", {32'h0, RD2D}, {32'h0, exp_read(Rs2D)});
                check("rd1_w4", {32'h0, s_RD1D}, {32'h0, exp_read(Rs1D)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic w, input logic [1:0] src,
                          input logic [31:0] val, input logic [4:0] rd);
        ValidW = v; RegWriteW = w; ResultSrcW = src; RdW = rd;
        ALUResultW = 32'hA0A0_0000; ReadDataW = 32'hB0B0_0000;
        PCPlus4W = 32'hC0C0_0000; ImmExtW = 32'hD0D0_0000;
        case (src)
            2'b00: ALUResultW = val;
            2'b01: ReadDataW = val;
            2'b10: PCPlus4W = val;
            default: ImmExtW = val;
        endcase
    endtask

    logic [31:0] old3;

    initial begin
        rst = 1;
        set_wb(1, 1, 2'b00, 32'h0000_AAAA, 5'd5);
        Rs1D = 5'd5; Rs2D = 5'd0;
        tick();
        chk_en = 1;
        tick();
        // Reset release: x5 untouched by the write presented during reset.
        rst = 0;
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        #3;
        check("rst_x5", {32'h0, RD1D}, 64'h0);
        check("rst_instret", InstRetW, 64'h0);

        tick();
        set_wb(1, 1, 2'b01, 32'hDEADBEEF, 5'd7);
        Rs1D = 5'd7; Rs2D = 5'd0;
        #3;
        check("mux_mem", {32'h0, ResultW}, 64'hDEADBEEF);
        tick();
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        #3;
        check("wr_x7", {32'h0, RD1D}, 64'hDEADBEEF);
        check("cnt_1", InstRetW, 64'd1);

        tick();
        set_wb(1, 1, 2'b00, 32'hFFFFFFFF, 5'd0);
        Rs1D = 5'd0; Rs2D = 5'd0;
        #3;
        check("x0_same", {32'h0, RD1D}, 64'h0);
        tick();
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        #3;
        check("x0_after", {32'h0, RD1D}, 64'h0);
        check("cnt_2", InstRetW, 64'd2);

        tick();
        set_wb(1, 1, 2'b11, 32'h1111_1111, 5'd3);
        tick();
        set_wb(1, 1, 2'b10, 32'h12345678, 5'd3);
        Rs1D = 5'd3; Rs2D = 5'd3;
`ifdef WB_RF_BYPASS_EN
        old3 = 32'h12345678;
`else
        old3 = 32'h1111_1111;
`endif
        #3;
        check("coll_rd1", {32'h0, RD1D}, {32'h0, old3});
        check("coll_rd2", {32'h0, RD2D}, {32'h0, old3});
        tick();
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        #3;
        check("coll_after", {32'h0, RD2D}, 64'h12345678);
        check("cnt_4", InstRetW, 64'd4);

        tick();
        set_wb(0, 1, 2'b00, 32'h0000_0099, 5'd9);
        Rs1D = 5'd9;
        tick();
        set_wb(1, 0, 2'b00, 32'h0000_0099, 5'd9);
        #3;
        check("bubble_x9", {32'h0, RD1D}, 64'h0);
        check("bubble_cnt", InstRetW, 64'd4);
        tick();
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        #3;
        check("store_x9", {32'h0, RD1D}, 64'h0);
        check("store_cnt", InstRetW, 64'd5);

        // Eleven more retirements take the 4-bit counter from 5 through 15 to 0.
        set_wb(1, 0, 2'b00, 32'h0, 5'd0);
        for (int i = 0; i < 11; i++) tick();
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        #3;
        check("wrap_w4", {60'h0, s_InstRetW}, 64'h0);
        check("cnt_16", InstRetW, 64'd16);

        for (int n = 0; n < 400; n++) begin
            tick();
            rst = ($urandom_range(0, 59) == 0);
            set_wb($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            ALUResultW = $urandom;
            PCPlus4W   = $urandom;
            Rs1D = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
            Rs2D = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom_range(0, 31));
        end
        tick();
        rst = 0;
        set_wb(0, 0, 2'b00, 32'h0, 5'd0);
        tick();
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
